// File: rtl/turfio_pkg.sv
// Shared constants for the TURF->TURFIO command output link.
// Frame geometry and the default alignment pattern live here.
package turfio_pkg;

    localparam int unsigned COUT_FRAME_CYCLES = 16;
    localparam int unsigned COUT_BITS = 2 * COUT_FRAME_CYCLES;
    localparam logic [COUT_BITS-1:0] TURFIO_TRAIN_PATTERN = 32'hA55A6996;

    function automatic logic [COUT_BITS-1:0] cout_frame_word(
        input logic                 train,
        input logic [COUT_BITS-1:0] pattern,
        input logic [COUT_BITS-1:0] command
    );
        return train ? pattern : command;
    endfunction

endpackage

// File: rtl/turfio_cout_oddr.sv
// Generic same-edge DDR output cell: d1 out in the high half, d2 in the low half.
// Behavioural model; swap in the vendor ODDR primitive at this boundary for a board build.
module turfio_cout_oddr (
    input  logic clk,
    input  logic rst,
    input  logic d1,
    input  logic d2,
    output logic q
);

    logic r_q1;
    logic r_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
        end else begin
            r_q1 <= d1;
            r_q2 <= d2;
        end
    end

    assign q = clk ? r_q1 : r_q2;

endmodule

// File: rtl/turfio_cout_tx.sv
// TURF->TURFIO command serializer: one 32-bit word per 16-cycle frame, MSB first,
// two bits per if_clk_x2 cycle, with a forwarded source-synchronous clock.
module turfio_cout_tx
    import turfio_pkg::*;
#(
    parameter logic [COUT_BITS-1:0] TRAIN_PATTERN = TURFIO_TRAIN_PATTERN,
    parameter bit                   INVERT_COUT   = 1'b0
) (
    input  logic                 if_clk_x2_i,
    input  logic                 if_rst_i,
    input  logic                 if_clk_i,
    input  logic                 if_clk_x2_phase_i,
    input  logic [COUT_BITS-1:0] cout_command_i,
    input  logic                 cout_train_i,
    output logic                 COUT_P,
    output logic                 TXCLK_P
);

    logic [COUT_BITS-1:0] r_sr;
    logic                 w_cout_q;
    logic                 w_unused_clk;

    assign w_unused_clk = if_clk_i;

    // A phase pulse always reloads, so an early pulse aborts the frame in flight.
    always_ff @(posedge if_clk_x2_i) begin
        if (if_rst_i) begin
            r_sr <= '0;
        end else if (if_clk_x2_phase_i) begin
            r_sr <= cout_frame_word(cout_train_i, TRAIN_PATTERN, cout_command_i);
        end else begin
            r_sr <= {r_sr[COUT_BITS-3:0], 2'b00};
        end
    end

    turfio_cout_oddr u_cout_oddr (
        .clk (if_clk_x2_i),
        .rst (if_rst_i),
        .d1  (r_sr[COUT_BITS-1]),
        .d2  (r_sr[COUT_BITS-2]),
        .q   (w_cout_q)
    );

    turfio_cout_oddr u_txclk_oddr (
        .clk (if_clk_x2_i),
        .rst (if_rst_i),
        .d1  (1'b1),
        .d2  (1'b0),
        .q   (TXCLK_P)
    );

    // Inversion sits after the cell so reset drives the line to its idle level.
    assign COUT_P = w_cout_q ^ INVERT_COUT;

endmodule

// File: tb/tb_turfio_cout_tx.sv
// Directed bench for turfio_cout_tx: samples each DDR half-cycle and
// rebuilds frames to compare against hand-computed words.
module tb_turfio_cout_tx;

    logic        clk = 1'b0;
    logic        clk_div = 1'b0;
    logic        rst = 1'b1;
    logic        phase = 1'b0;
    logic [31:0] cmd = 32'h0;
    logic        train = 1'b0;
    logic        cout;
    logic        txclk;

    int n_tests = 0;
    int n_fail = 0;

    logic s_hi, s_lo, s_txh, s_txl;
    logic hi_a [16];
    logic lo_a [16];

    always #5 clk = ~clk;
    always @(posedge clk) clk_div <= ~clk_div;

    turfio_cout_tx dut (
        .if_clk_x2_i       (clk),
        .if_rst_i          (rst),
        .if_clk_i          (clk_div),
        .if_clk_x2_phase_i (phase),
        .cout_command_i    (cmd),
        .cout_train_i      (train),
        .COUT_P            (cout),
        .TXCLK_P           (txclk)
    );

    task automatic step();
        @(posedge clk);
        #2;
        s_hi = cout;
        s_txh = txclk;
        #5;
        s_lo = cout;
        s_txl = txclk;
    endtask

    task automatic pulse_step();
        phase = 1'b1;
        step();
        phase = 1'b0;
    endtask

    task automatic recv(input int n, input int pulse_at, output logic [31:0] w);
        w = '0;
        for (int k = 0; k < n; k++) begin
            phase = (k == pulse_at);
            step();
            phase = 1'b0;
            hi_a[k] = s_hi;
            lo_a[k] = s_lo;
            w = {w[29:0], s_hi, s_lo};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if ({s_hi, s_lo, s_txh, s_txl} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got cout=%b%b txclk=%b%b want 00 00",
                         i, s_hi, s_lo, s_txh, s_txl);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({s_hi, s_lo, s_txh, s_txl} !== 4'b0010) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got cout=%b%b txclk=%b%b want 00 10",
                         i, s_hi, s_lo, s_txh, s_txl);
            end
        end
    endtask

    task automatic test_training();
        logic [31:0] w;
        train = 1'b1;
        cmd = 32'h1234_5678;
        pulse_step();
        for (int f = 0; f < 3; f++) begin
            recv(16, 15, w);
            n_tests++;
            if (w !== 32'hA55A6996) begin
                n_fail++;
                $display("FAIL train_frame%0d got %h want a55a6996", f, w);
            end
        end
        recv(16, -1, w);
        n_tests++;
        if (w !== 32'hA55A6996) begin
            n_fail++;
            $display("FAIL train_last got %h want a55a6996", w);
        end
        recv(4, -1, w);
        n_tests++;
        if (w[7:0] !== 8'h00) begin
            n_fail++;
            $display("FAIL train_tail got %h want 00", w[7:0]);
        end
    endtask

    task automatic test_command();
        logic [31:0] a, b, w;
        int ones;
        train = 1'b1;
        pulse_step();
        recv(8, -1, a);
        train = 1'b0;
        cmd = 32'h0001_0000;
        recv(8, 7, b);
        n_tests++;
        if ({a[15:0], b[15:0]} !== 32'hA55A6996) begin
            n_fail++;
            $display("FAIL cmd_train_tail got %h want a55a6996", {a[15:0], b[15:0]});
        end
        recv(16, -1, w);
        n_tests++;
        if (w !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL cmd_frame got %h want 00010000", w);
        end
        ones = 0;
        for (int k = 0; k < 16; k++) ones += int'(hi_a[k]) + int'(lo_a[k]);
        n_tests++;
        if (lo_a[7] !== 1'b1 || ones != 1) begin
            n_fail++;
            $display("FAIL cmd_bit16 got lo7=%b ones=%0d want lo7=1 ones=1", lo_a[7], ones);
        end
    endtask

    task automatic test_cmd_change();
        logic [31:0] a, b, w;
        cmd = 32'hFFFF_FFFF;
        pulse_step();
        recv(6, -1, a);
        cmd = 32'h0;
        recv(10, 9, b);
        n_tests++;
        if ({a[11:0], b[19:0]} !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL chg_ones got %h want ffffffff", {a[11:0], b[19:0]});
        end
        recv(16, -1, w);
        n_tests++;
        if (w !== 32'h0) begin
            n_fail++;
            $display("FAIL chg_zero got %h want 00000000", w);
        end
    endtask

    task automatic test_early_pulse();
        logic [31:0] a, w;
        cmd = 32'h1234_5678;
        pulse_step();
        cmd = 32'hCAFE_F00D;
        recv(5, 4, a);
        n_tests++;
        if (a[9:0] !== 10'h048) begin
            n_fail++;
            $display("FAIL early_trunc got %h want 048", a[9:0]);
        end
        recv(16, -1, w);
        n_tests++;
        if (w !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL early_new got %h want cafef00d", w);
        end
        recv(16, -1, w);
        n_tests++;
        if (w !== 32'h0) begin
            n_fail++;
            $display("FAIL missing_pulse got %h want 00000000", w);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, w;
        cmd = 32'hDEAD_BEEF;
        pulse_step();
        recv(4, -1, a);
        n_tests++;
        if (a[7:0] !== 8'hDE) begin
            n_fail++;
            $display("FAIL rstmid_pre got %h want de", a[7:0]);
        end
        rst = 1'b1;
        phase = 1'b1;
        step();
        phase = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            n_tests++;
            if ({s_hi, s_lo, s_txh, s_txl} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rstmid_hold cyc=%0d got cout=%b%b txclk=%b%b want 00 00",
                         i, s_hi, s_lo, s_txh, s_txl);
            end
        end
        rst = 1'b0;
        recv(16, -1, w);
        n_tests++;
        if (w !== 32'h0 || s_txh !== 1'b1 || s_txl !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle got %h tx=%b%b want 00000000 tx=10", w, s_txh, s_txl);
        end
        pulse_step();
        recv(16, -1, w);
        n_tests++;
        if (w !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rstmid_frame got %h want deadbeef", w);
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_command();
        test_cmd_change();
        test_early_pulse();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
